// File: rtl/wb_packet_cmd_parser.sv
// Byte-stream command front end for the wishbone packet master: decodes read/write
// frames, launches one transfer at a time and streams back a status byte plus read data.
module wb_packet_cmd_parser #(
  parameter int ADDRESS_WIDTH      = 16,
  parameter int MAX_PAYLOAD        = 8,
  parameter int INTERFACE_LENGTH_N = 4,
  parameter int GAP_TIMEOUT        = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [ADDRESS_WIDTH-1:0]      transfer_address,
  output logic [MAX_PAYLOAD*8-1:0]      payload_in,
  input  logic [MAX_PAYLOAD*8-1:0]      payload_out,
  output logic [INTERFACE_LENGTH_N-1:0] payload_length,
  output logic                          start_read,
  output logic                          start_write,
  input  logic                          read_busy,
  input  logic                          write_busy,
  input  logic                          completed,
  input  logic                          timeout
);

  localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
  localparam int ADDR_CNT_W = $clog2(ADDR_BYTES + 1);
  localparam int CNT_W      = $clog2(MAX_PAYLOAD + 1);
  localparam int GAP_W      = $clog2(GAP_TIMEOUT + 1);
  localparam int PW         = MAX_PAYLOAD * 8;

  localparam logic [ADDR_CNT_W-1:0] ADDR_LAST = ADDR_CNT_W'(ADDR_BYTES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);

  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BAD_CMD = 8'h02;
  localparam logic [7:0] ST_BAD_LEN = 8'h03;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_RESP  = 3'd6,
    S_RDATA = 3'd7
  } state_t;

  state_t                        state_r;
  logic                          rx_ready_r;
  logic [7:0]                    tx_data_r;
  logic                          tx_valid_r;
  logic [ADDRESS_WIDTH-1:0]      addr_r;
  logic [PW-1:0]                 payload_in_r;
  logic [PW-1:0]                 rbuf_r;
  logic [INTERFACE_LENGTH_N-1:0] payload_length_r;
  logic                          start_read_r;
  logic                          start_write_r;
  logic                          is_write_r;
  logic [CNT_W-1:0]              byte_cnt_r;
  logic [ADDR_CNT_W-1:0]         addr_cnt_r;
  logic [GAP_W-1:0]              gap_cnt_r;

  logic                          rx_fire_s;
  logic                          tx_fire_s;
  logic                          gap_idle_s;
  logic                          len_bad_s;
  logic [CNT_W-1:0]              len_last_s;

  assign rx_fire_s  = rx_valid && rx_ready_r;
  assign tx_fire_s  = tx_valid_r && tx_ready;
  assign gap_idle_s = ((state_r == S_ADDR) || (state_r == S_LEN) || (state_r == S_DATA)) && !rx_valid;
  assign len_bad_s  = (rx_data == 8'h00) || (rx_data > 8'(MAX_PAYLOAD));
  assign len_last_s = CNT_W'(payload_length_r) - CNT_W'(1);

  // Frame parser, transfer launch and response sequencer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r          <= S_CMD;
      rx_ready_r       <= 1'b0;
      tx_data_r        <= 8'h00;
      tx_valid_r       <= 1'b0;
      addr_r           <= {ADDRESS_WIDTH{1'b0}};
      payload_in_r     <= {PW{1'b0}};
      rbuf_r           <= {PW{1'b0}};
      payload_length_r <= {INTERFACE_LENGTH_N{1'b0}};
      start_read_r     <= 1'b0;
      start_write_r    <= 1'b0;
      is_write_r       <= 1'b0;
      byte_cnt_r       <= {CNT_W{1'b0}};
      addr_cnt_r       <= {ADDR_CNT_W{1'b0}};
      gap_cnt_r        <= {GAP_W{1'b0}};
    end else begin
      start_read_r  <= 1'b0;
      start_write_r <= 1'b0;
      if (gap_idle_s) begin
        // A stalled partial frame is dropped without a response.
        if (gap_cnt_r == GAP_LAST) begin
          state_r   <= S_CMD;
          gap_cnt_r <= {GAP_W{1'b0}};
        end else begin
          gap_cnt_r <= gap_cnt_r + GAP_W'(1);
        end
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
        case (state_r)
          S_CMD: begin
            rx_ready_r <= 1'b1;
            if (rx_fire_s) begin
              if ((rx_data == OP_READ) || (rx_data == OP_WRITE)) begin
                is_write_r <= (rx_data == OP_WRITE);
                addr_cnt_r <= {ADDR_CNT_W{1'b0}};
                state_r    <= S_ADDR;
              end else begin
                tx_data_r  <= ST_BAD_CMD;
                tx_valid_r <= 1'b1;
                rx_ready_r <= 1'b0;
                state_r    <= S_RESP;
              end
            end
          end
          S_ADDR: begin
            if (rx_fire_s) begin
              addr_r <= (addr_r << 4'd8) | ADDRESS_WIDTH'(rx_data);
              if (addr_cnt_r == ADDR_LAST) begin
                state_r <= S_LEN;
              end else begin
                addr_cnt_r <= addr_cnt_r + ADDR_CNT_W'(1);
              end
            end
          end
          S_LEN: begin
            if (rx_fire_s) begin
              if (len_bad_s) begin
                tx_data_r  <= ST_BAD_LEN;
                tx_valid_r <= 1'b1;
                rx_ready_r <= 1'b0;
                state_r    <= S_RESP;
              end else begin
                payload_length_r <= INTERFACE_LENGTH_N'(rx_data);
                byte_cnt_r       <= {CNT_W{1'b0}};
                if (is_write_r) begin
                  payload_in_r <= {PW{1'b0}};
                  state_r      <= S_DATA;
                end else begin
                  rx_ready_r <= 1'b0;
                  state_r    <= S_START;
                end
              end
            end
          end
          S_DATA: begin
            if (rx_fire_s) begin
              for (int i = 0; i < MAX_PAYLOAD; i++) begin
                if (byte_cnt_r == CNT_W'(i)) begin
                  payload_in_r[8*i +: 8] <= rx_data;
                end
              end
              if (byte_cnt_r == len_last_s) begin
                rx_ready_r <= 1'b0;
                state_r    <= S_START;
              end else begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
              end
            end
          end
          S_START: begin
            if (!read_busy && !write_busy) begin
              start_write_r <= is_write_r;
              start_read_r  <= !is_write_r;
              state_r       <= S_WAIT;
            end
          end
          S_WAIT: begin
            // Timeout wins when both strobes land together.
            if (timeout) begin
              tx_data_r  <= ST_TIMEOUT;
              tx_valid_r <= 1'b1;
              state_r    <= S_RESP;
            end else if (completed) begin
              tx_data_r  <= ST_OK;
              tx_valid_r <= 1'b1;
              rbuf_r     <= payload_out;
              state_r    <= S_RESP;
            end else begin
              state_r <= S_WAIT;
            end
          end
          S_RESP: begin
            if (tx_fire_s) begin
              if (!is_write_r && (tx_data_r == ST_OK)) begin
                tx_data_r  <= rbuf_r[7:0];
                rbuf_r     <= rbuf_r >> 4'd8;
                byte_cnt_r <= {CNT_W{1'b0}};
                state_r    <= S_RDATA;
              end else begin
                tx_valid_r <= 1'b0;
                rx_ready_r <= 1'b1;
                state_r    <= S_CMD;
              end
            end
          end
          S_RDATA: begin
            if (tx_fire_s) begin
              if (byte_cnt_r == len_last_s) begin
                tx_valid_r <= 1'b0;
                rx_ready_r <= 1'b1;
                state_r    <= S_CMD;
              end else begin
                tx_data_r  <= rbuf_r[7:0];
                rbuf_r     <= rbuf_r >> 4'd8;
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
              end
            end
          end
          default: begin
            tx_valid_r <= 1'b0;
            rx_ready_r <= 1'b0;
            state_r    <= S_CMD;
          end
        endcase
      end
    end
  end

  assign rx_ready         = rx_ready_r;
  assign tx_data          = tx_data_r;
  assign tx_valid         = tx_valid_r;
  assign transfer_address = addr_r;
  assign payload_in       = payload_in_r;
  assign payload_length   = payload_length_r;
  assign start_read       = start_read_r;
  assign start_write      = start_write_r;

endmodule

// File: tb/tb_wb_packet_cmd_parser.sv
// Randomised scoreboard bench for wb_packet_cmd_parser: a frame-level model predicts
// master transfers and response bytes; separate monitors pop and compare them.
module tb_wb_packet_cmd_parser;

  localparam int AW  = 16;
  localparam int MP  = 8;
  localparam int LN  = 4;
  localparam int GAP = 1024;
  localparam int AB  = AW / 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [AW-1:0]   transfer_address;
  logic [MP*8-1:0] payload_in;
  logic [MP*8-1:0] payload_out;
  logic [LN-1:0]   payload_length;
  logic            start_read;
  logic            start_write;
  logic            read_busy;
  logic            write_busy;
  logic            completed;
  logic            timeout;

  always #5 clk_i = ~clk_i;

  wb_packet_cmd_parser #(
    .ADDRESS_WIDTH(AW), .MAX_PAYLOAD(MP), .INTERFACE_LENGTH_N(LN), .GAP_TIMEOUT(GAP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .transfer_address(transfer_address), .payload_in(payload_in), .payload_out(payload_out),
    .payload_length(payload_length), .start_read(start_read), .start_write(start_write),
    .read_busy(read_busy), .write_busy(write_busy), .completed(completed), .timeout(timeout)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic            is_write;
    logic [AW-1:0]   addr;
    logic [LN-1:0]   len;
    logic [MP*8-1:0] payload;
    logic [MP*8-1:0] rdata;
    logic            tmo;
    logic            both;
    int              delay;
    logic            abort;
  } tr_t;

  tr_t        exp_tr[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  int         start_cnt = 0;
  logic       hold_tx = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {rx_ready, tx_valid, tx_data, start_read, start_write}, 64'd0);
    chk({name, "_addr"}, transfer_address, 64'd0);
    chk({name, "_payload"}, payload_in, 64'd0);
    chk({name, "_len"}, payload_length, 64'd0);
  endtask

  // Response sink readiness: random, or forced low for backpressure tests.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      tx_ready = hold_tx ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor: pops expected bytes on each accepted beat and checks stall stability.
  initial begin : tx_mon
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", tx_data, e);
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Master model: checks each start pulse against the predicted transfer, then completes it.
  initial begin : master
    tr_t t;
    completed   = 1'b0;
    timeout     = 1'b0;
    payload_out = '0;
    forever begin
      @(negedge clk_i);
      payload_out = {$urandom, $urandom};
      if (!rst_i && (start_read || start_write)) begin
        start_cnt++;
        if (exp_tr.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_unexpected: got rd=%0b wr=%0b expected no start", start_read, start_write);
        end else begin
          t = exp_tr.pop_front();
          chk("start_kind", {start_write, start_read}, {t.is_write, !t.is_write});
          chk("addr", transfer_address, t.addr);
          chk("len", payload_length, t.len);
          if (t.is_write) chk("payload_in", payload_in, t.payload);
          @(negedge clk_i);
          chk("start_pulse_width", {start_write, start_read}, 64'd0);
          repeat (t.delay) @(negedge clk_i);
          if (!t.abort) begin
            chk("addr_hold", transfer_address, t.addr);
            chk("len_hold", payload_length, t.len);
            if (t.is_write) chk("payload_hold", payload_in, t.payload);
            completed   = !t.tmo || t.both;
            timeout     = t.tmo;
            payload_out = t.rdata;
            @(negedge clk_i);
            completed   = 1'b0;
            timeout     = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_i);
    while (!rx_ready && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_accept_timeout: got rx_ready=0 expected 1 for byte %h", b);
    end
    @(posedge clk_i); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    if (n > 0) begin
      repeat (n) @(posedge clk_i);
      #1;
    end
  endtask

  // Frame-level reference: predicts the transfer and response bytes, then streams the frame.
  task automatic do_frame(input bq_t fr, input logic [63:0] rdata, input logic tmo, input logic both,
                          input int delay, input logic abort, input int gap_at, input int gap_len);
    tr_t t;
    logic [7:0] op;
    logic [7:0] ln;
    op = fr[0];
    if (op != 8'h52 && op != 8'h57) begin
      exp_tx.push_back(8'h02);
    end else begin
      ln = fr[1 + AB];
      if (ln == 8'd0 || ln > 8'(MP)) begin
        exp_tx.push_back(8'h03);
      end else begin
        t.is_write = (op == 8'h57);
        t.addr = '0;
        for (int i = 0; i < AB; i++) t.addr = (t.addr << 8) | AW'(fr[1 + i]);
        t.len = LN'(ln);
        t.payload = '0;
        if (t.is_write) for (int k = 0; k < int'(ln); k++) t.payload[8*k +: 8] = fr[2 + AB + k];
        t.rdata = rdata; t.tmo = tmo; t.both = both; t.delay = delay; t.abort = abort;
        exp_tr.push_back(t);
        if (!abort) begin
          if (tmo) begin
            exp_tx.push_back(8'h01);
          end else begin
            exp_tx.push_back(8'h00);
            if (!t.is_write) for (int k = 0; k < int'(ln); k++) exp_tx.push_back(rdata[8*k +: 8]);
          end
        end
      end
    end
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (i == gap_at) idle(gap_len);
      else if (i != fr.size() - 1) idle($urandom_range(0, 2));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_tr.size() != 0) && n < 5000) begin
      @(posedge clk_i);
      n++;
    end
    @(posedge clk_i); #1;
    checks++;
    if (exp_tx.size() != 0 || exp_tr.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bytes and %0d transfers pending expected 0", exp_tx.size(), exp_tr.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at time limit");
    $fatal(1, "time limit reached");
  end

  initial begin : main
    bq_t        fr;
    logic [7:0] op;
    logic [7:0] ln;
    int         r;
    int         s0;
    int         n;
    rst_i = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; read_busy = 1'b0; write_busy = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    check_zero("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    fr = '{8'h57, 8'h00, 8'h12, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    do_frame(fr, 64'd0, 1'b0, 1'b0, 2, 1'b0, -1, 0); drain();
    fr = '{8'h52, 8'h00, 8'h12, 8'h04};
    do_frame(fr, 64'h0000_0000_2524_2322, 1'b0, 1'b0, 1, 1'b0, -1, 0); drain();

    fr = '{8'h41}; do_frame(fr, 64'd0, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    fr = '{8'h52, 8'h00, 8'h00, 8'h09}; do_frame(fr, 64'd0, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    fr = '{8'h57, 8'h00, 8'h00, 8'h00}; do_frame(fr, 64'd0, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    drain();

    fr = '{8'h52, 8'h00, 8'h40, 8'h03};
    do_frame(fr, {$urandom, $urandom}, 1'b1, 1'b1, 3, 1'b0, -1, 0); drain();
    fr = '{8'h57, 8'h00, 8'h41, 8'h01, 8'h5A};
    do_frame(fr, {$urandom, $urandom}, 1'b1, 1'b0, 0, 1'b0, -1, 0); drain();

    hold_tx = 1'b1;
    fr = '{8'h52, 8'hAB, 8'hCD, 8'h04};
    do_frame(fr, {$urandom, $urandom}, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    n = 0;
    while (!tx_valid && n < 200) begin @(posedge clk_i); #1; n++; end
    chk("bp_tx_valid", tx_valid, 64'd1);
    repeat (5) @(posedge clk_i); #1;
    hold_tx = 1'b0;
    drain();

    read_busy = 1'b1; s0 = start_cnt;
    fr = '{8'h52, 8'h00, 8'h20, 8'h02};
    do_frame(fr, {$urandom, $urandom}, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    repeat (8) @(posedge clk_i); #1;
    chk("busy_blocks_start", start_cnt, s0);
    read_busy = 1'b0; drain();
    write_busy = 1'b1; s0 = start_cnt;
    fr = '{8'h57, 8'h00, 8'h21, 8'h01, 8'h77};
    do_frame(fr, {$urandom, $urandom}, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    repeat (6) @(posedge clk_i); #1;
    chk("wbusy_blocks_start", start_cnt, s0);
    write_busy = 1'b0; drain();

    send_byte(8'h57); send_byte(8'h00); idle(GAP + 4);
    fr = '{8'h52, 8'h00, 8'h10, 8'h01};
    do_frame(fr, {$urandom, $urandom}, 1'b0, 1'b0, 1, 1'b0, -1, 0); drain();
    fr = '{8'h57, 8'h00, 8'h12, 8'h01, 8'hAA};
    do_frame(fr, 64'd0, 1'b0, 1'b0, 0, 1'b0, 1, GAP - 8); drain();

    s0 = start_cnt;
    fr = '{8'h52, 8'h00, 8'h30, 8'h02};
    do_frame(fr, {$urandom, $urandom}, 1'b0, 1'b0, 40, 1'b1, -1, 0);
    n = 0;
    while (start_cnt == s0 && n < 200) begin @(posedge clk_i); #1; n++; end
    chk("rst_test_started", start_cnt, s0 + 1);
    repeat (3) @(posedge clk_i); #2;
    rst_i = 1'b1; #1;
    check_zero("rst_in_wait");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (60) @(posedge clk_i); #1;
    drain();

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      fr.delete();
      if (r == 0) begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h52 || op == 8'h57) op = 8'h00;
        fr.push_back(op);
      end else begin
        op = ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52;
        fr.push_back(op);
        for (int i = 0; i < AB; i++) fr.push_back(8'($urandom_range(0, 255)));
        if (r == 1) begin
          ln = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MP + 1, 255));
          fr.push_back(ln);
        end else begin
          ln = 8'($urandom_range(1, MP));
          fr.push_back(ln);
          if (op == 8'h57) for (int k = 0; k < int'(ln); k++) fr.push_back(8'($urandom_range(0, 255)));
        end
      end
      do_frame(fr, {$urandom, $urandom}, ($urandom_range(0, 6) == 0), ($urandom_range(0, 1) != 0),
               $urandom_range(0, 5), 1'b0, -1, 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
